// File: rtl/sobel_seq_pkg.sv
// -----------------------------------------------------------------------------
// sobel_seq_pkg
// Shared types and defaults for the Sobel stage sequencer:
//   - seq_state_t    : sequencer FSM state encoding
//   - SEQ_NUM_STAGES : default number of sequenced stages
//   - SEQ_CNT_W      : default width of a per-stage profiling counter
//   - stage_idx_t    : stage index type for the default stage count
// -----------------------------------------------------------------------------
package sobel_seq_pkg;

  localparam int SEQ_NUM_STAGES = 4;
  localparam int SEQ_CNT_W      = 32;

  typedef logic [$clog2(SEQ_NUM_STAGES)-1:0] stage_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sobel_seq_next_stage.sv
// -----------------------------------------------------------------------------
// sobel_seq_next_stage
// Combinational priority encoder: returns the lowest set mask bit strictly
// above the current index. The current index is signed so that -1 selects
// the lowest set bit overall (first-stage pick at run start).
// Ports:
//   mask     in  NUM_STAGES  stage enable bits
//   cur_idx  in  IDX_W+1     current index, signed (-1 = before stage 0)
//   nxt_idx  out IDX_W       next enabled stage index (0 when none)
//   nxt_vld  out 1           a next enabled stage exists
// -----------------------------------------------------------------------------
module sobel_seq_next_stage #(
  parameter int NUM_STAGES = 4,
  parameter int IDX_W      = 2
) (
  input  logic [NUM_STAGES-1:0] mask,
  input  logic signed [IDX_W:0] cur_idx,
  output logic [IDX_W-1:0]      nxt_idx,
  output logic                  nxt_vld
);

  // Scan downward so the lowest qualifying index is the last one written.
  always_comb begin
    nxt_idx = '0;
    nxt_vld = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur_idx))) begin
        nxt_idx = IDX_W'(i);
        nxt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sobel_stage_sequencer.sv
// -----------------------------------------------------------------------------
// sobel_stage_sequencer
// Runs the enabled Sobel pipeline stages in index order under one block-level
// ap_ctrl_hs handshake, flags stray stage completions, and optionally profiles
// the cycles spent in each stage.
// Optional feature macro: SOBEL_SEQ_PROFILE_EN (per-stage cycle counters).
// Ports:
//   ap_clk, ap_rst_n      clock, asynchronous active-low reset
//   ap_start              block start, sampled in IDLE only
//   ap_done / ap_ready    one-cycle completion pulse (identical)
//   ap_idle               high while IDLE
//   stg_mask              stage enables, latched on accepted start
//   stg_start             one-hot start to the active stage
//   stg_ready, stg_done   per-stage handshake returns
//   cur_stage             active stage index, 0 when idle
//   err                   sticky stray-done flag, cleared on accepted start
//   prof_clr              synchronous clear of the profiling counters
//   prof_cycles           per-stage cycle counts, stage 0 in the LSBs
// All outputs decode registered state only.
// -----------------------------------------------------------------------------
module sobel_stage_sequencer
  import sobel_seq_pkg::*;
#(
  parameter int NUM_STAGES = SEQ_NUM_STAGES,
  parameter int CNT_W      = SEQ_CNT_W
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          ap_start,
  output logic                          ap_done,
  output logic                          ap_ready,
  output logic                          ap_idle,
  input  logic [NUM_STAGES-1:0]         stg_mask,
  output logic [NUM_STAGES-1:0]         stg_start,
  input  logic [NUM_STAGES-1:0]         stg_ready,
  input  logic [NUM_STAGES-1:0]         stg_done,
  output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
  output logic                          err,
  input  logic                          prof_clr,
  output logic [NUM_STAGES*CNT_W-1:0]   prof_cycles
);

  localparam int IDX_W = $clog2(NUM_STAGES);

  seq_state_t            state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [NUM_STAGES-1:0] mask_q, mask_nxt;
  logic                  err_nxt;
  logic                  start_acc;
  logic                  complete;
  logic                  stray;

  logic [NUM_STAGES-1:0] idx_onehot;
  logic [NUM_STAGES-1:0] enc_mask;
  logic signed [IDX_W:0] enc_cur;
  logic [IDX_W-1:0]      enc_idx;
  logic                  enc_vld;

  assign idx_onehot = NUM_STAGES'(1) << idx;

  // In IDLE the encoder looks at the live mask from "before stage 0" to pick
  // the first stage; otherwise it advances past idx within the latched mask.
  assign enc_mask = (state == ST_IDLE) ? stg_mask : mask_q;
  assign enc_cur  = (state == ST_IDLE) ? '1 : {1'b0, idx};

  sobel_seq_next_stage #(
    .NUM_STAGES (NUM_STAGES),
    .IDX_W      (IDX_W)
  ) u_next_stage (
    .mask    (enc_mask),
    .cur_idx (enc_cur),
    .nxt_idx (enc_idx),
    .nxt_vld (enc_vld)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      mask_q <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      mask_q <= mask_nxt;
      err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    mask_nxt  = mask_q;
    err_nxt   = err;
    start_acc = 1'b0;
    complete  = 1'b0;
    stray     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (ap_start) begin
          start_acc = 1'b1;
          mask_nxt  = stg_mask;
          err_nxt   = 1'b0;
          if (enc_vld) begin
            idx_nxt   = enc_idx;
            state_nxt = ST_LAUNCH;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_LAUNCH: begin
        // A done arriving together with ready is a completed stage.
        if (stg_ready[idx]) begin
          if (stg_done[idx]) complete = 1'b1;
          else               state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (stg_done[idx]) complete = 1'b1;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end
    endcase

    // Back-to-back launch of the next enabled stage, no idle cycle between.
    if (complete) begin
      if (enc_vld) begin
        idx_nxt   = enc_idx;
        state_nxt = ST_LAUNCH;
      end else begin
        state_nxt = ST_DONE;
      end
    end

    // Any done outside a running stage, or from a non-active stage, is stray.
    if ((state == ST_IDLE) || (state == ST_DONE)) stray = |stg_done;
    else                                          stray = |(stg_done & ~idx_onehot);
    if (stray) err_nxt = 1'b1;
  end

  assign ap_idle   = (state == ST_IDLE);
  assign ap_done   = (state == ST_DONE);
  assign ap_ready  = ap_done;
  assign stg_start = (state == ST_LAUNCH) ? idx_onehot : '0;
  assign cur_stage = idx;

`ifdef SOBEL_SEQ_PROFILE_EN
  logic [CNT_W-1:0] cnt [NUM_STAGES];
  logic             stage_active;

  assign stage_active = (state == ST_LAUNCH) || (state == ST_WAIT);

  // Clear beats increment; counters stick at all-ones.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_STAGES; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (prof_clr || start_acc) begin
          cnt[i] <= '0;
        end else if (stage_active && (idx == IDX_W'(i)) && (cnt[i] != '1)) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_prof
    assign prof_cycles[g*CNT_W +: CNT_W] = cnt[g];
  end
`else
  logic unused_prof;
  assign unused_prof = prof_clr ^ start_acc;
  assign prof_cycles = '0;
`endif

endmodule

// File: tb/tb_sobel_stage_sequencer.sv
module tb_sobel_stage_sequencer;

  localparam int NS  = 4;
  localparam int CW  = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          ap_start;
  logic          ap_done;
  logic          ap_ready;
  logic          ap_idle;
  logic [NS-1:0] stg_mask;
  logic [NS-1:0] stg_start;
  logic [NS-1:0] stg_ready;
  logic [NS-1:0] stg_done;
  logic [1:0]    cur_stage;
  logic          err;
  logic          prof_clr;
  logic [NS*CW-1:0] prof_cycles;

  always #5 ap_clk = ~ap_clk;

  sobel_stage_sequencer #(
    .NUM_STAGES (NS),
    .CNT_W      (CW)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .ap_done     (ap_done),
    .ap_ready    (ap_ready),
    .ap_idle     (ap_idle),
    .stg_mask    (stg_mask),
    .stg_start   (stg_start),
    .stg_ready   (stg_ready),
    .stg_done    (stg_done),
    .cur_stage   (cur_stage),
    .err         (err),
    .prof_clr    (prof_clr),
    .prof_cycles (prof_cycles)
  );

  // One entry per clock cycle: inputs to drive and outputs expected.
  typedef struct {
    bit         start;
    logic [3:0] mask;
    logic [3:0] rdy;
    logic [3:0] dn;
    bit         clr;
    bit         spur;
    logic [3:0] e_start;
    bit         e_done;
    bit         e_idle;
    logic [1:0] e_cur;
    bit         chk_cur;
  } cyc_t;

  cyc_t sched[$];
  int   rd_cfg[NS];
  int   dd_cfg[NS];
  int   exp_prof[NS];
  bit   m_err;
  int   n_cmp;
  int   n_fail;

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  // Reference run: each enabled stage occupies rd+1 launch cycles plus dd
  // wait cycles; run ends with one DONE cycle.
  task automatic add_run(input logic [3:0] mask, input bit hold);
    cyc_t c;
    int   n;
    c = '{default: 0};
    c.start = 1'b1; c.mask = mask; c.rdy = 4'($urandom);
    c.e_idle = 1'b1; c.chk_cur = 1'b1; c.e_cur = 2'd0;
    sched.push_back(c);
    for (int k = 0; k < NS; k++) begin
      exp_prof[k] = 0;
      if (mask[k]) begin
        n = rd_cfg[k] + dd_cfg[k] + 1;
        exp_prof[k] = sat(n);
        for (int j = 0; j < n; j++) begin
          c = '{default: 0};
          c.mask = 4'($urandom);
          c.rdy  = 4'($urandom) & ~(4'b0001 << k);
          if (j == rd_cfg[k]) c.rdy[k] = 1'b1;
          if (j == rd_cfg[k] + dd_cfg[k]) c.dn[k] = 1'b1;
          if (j <= rd_cfg[k]) c.e_start[k] = 1'b1;
          c.e_cur = 2'(k); c.chk_cur = 1'b1;
          sched.push_back(c);
        end
      end
    end
    c = '{default: 0};
    c.start = hold; c.mask = 4'($urandom); c.rdy = 4'($urandom);
    c.e_done = 1'b1;
    sched.push_back(c);
  endtask

  task automatic add_idle(input int n);
    cyc_t c;
    for (int j = 0; j < n; j++) begin
      c = '{default: 0};
      c.rdy = 4'($urandom); c.mask = 4'($urandom);
      c.e_idle = 1'b1; c.chk_cur = 1'b1; c.e_cur = 2'd0;
      sched.push_back(c);
    end
  endtask

  task automatic rand_cfg(input int rmax, input int dmax);
    for (int k = 0; k < NS; k++) begin
      rd_cfg[k] = $urandom_range(rmax, 0);
      dd_cfg[k] = $urandom_range(dmax, 0);
    end
  endtask

  task automatic play(input int n, input string tag);
    for (int i = 0; i < sched.size() && i < n; i++) begin
      @(posedge ap_clk); #1;
      ap_start  = sched[i].start;
      stg_mask  = sched[i].mask;
      stg_ready = sched[i].rdy;
      stg_done  = sched[i].dn;
      prof_clr  = sched[i].clr;
      @(negedge ap_clk);
      n_cmp++;
      if (stg_start !== sched[i].e_start) begin
        n_fail++;
        $display("FAIL %s.stg_start cyc=%0d got=%b exp=%b", tag, i, stg_start, sched[i].e_start);
      end
      n_cmp++;
      if (ap_done !== sched[i].e_done) begin
        n_fail++;
        $display("FAIL %s.ap_done cyc=%0d got=%b exp=%b", tag, i, ap_done, sched[i].e_done);
      end
      n_cmp++;
      if (ap_ready !== sched[i].e_done) begin
        n_fail++;
        $display("FAIL %s.ap_ready cyc=%0d got=%b exp=%b", tag, i, ap_ready, sched[i].e_done);
      end
      n_cmp++;
      if (ap_idle !== sched[i].e_idle) begin
        n_fail++;
        $display("FAIL %s.ap_idle cyc=%0d got=%b exp=%b", tag, i, ap_idle, sched[i].e_idle);
      end
      n_cmp++;
      if (err !== m_err) begin
        n_fail++;
        $display("FAIL %s.err cyc=%0d got=%b exp=%b", tag, i, err, m_err);
      end
      if (sched[i].chk_cur) begin
        n_cmp++;
        if (cur_stage !== sched[i].e_cur) begin
          n_fail++;
          $display("FAIL %s.cur_stage cyc=%0d got=%0d exp=%0d", tag, i, cur_stage, sched[i].e_cur);
        end
      end
      if (sched[i].spur) m_err = 1'b1;
      else if (sched[i].start && sched[i].e_idle) m_err = 1'b0;
    end
    @(posedge ap_clk); #1;
    ap_start = 1'b0; stg_mask = '0; stg_ready = '0; stg_done = '0; prof_clr = 1'b0;
  endtask

  task automatic check_prof(input string tag);
    int exp_v;
    int got_v;
    @(negedge ap_clk);
    for (int k = 0; k < NS; k++) begin
`ifdef SOBEL_SEQ_PROFILE_EN
      exp_v = exp_prof[k];
`else
      exp_v = 0;
`endif
      got_v = int'(prof_cycles[k*CW +: CW]);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s.prof[%0d] got=%0d exp=%0d", tag, k, got_v, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    ap_start = 1'b0; stg_mask = '0; stg_ready = '0; stg_done = '0; prof_clr = 1'b0;
    m_err = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    n_cmp++;
    if ({ap_idle, ap_done, ap_ready, err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset.ctrl got=%b exp=1000", {ap_idle, ap_done, ap_ready, err});
    end
    n_cmp++;
    if ({stg_start, cur_stage} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset.stage got=%b exp=000000", {stg_start, cur_stage});
    end
    n_cmp++;
    if (prof_cycles !== '0) begin
      n_fail++;
      $display("FAIL reset.prof got=%h exp=0", prof_cycles);
    end
    ap_rst_n = 1'b1;
  endtask

  task automatic test_all_stages();
    sched.delete();
    for (int k = 0; k < NS; k++) begin rd_cfg[k] = 0; dd_cfg[k] = 4; end
    add_run(4'b1111, 1'b0);
    add_idle(2);
    play(sched.size(), "all_stages");
    check_prof("all_stages");
  endtask

  task automatic test_sparse_mask();
    sched.delete();
    rand_cfg(2, 3);
    add_run(4'b1010, 1'b0);
    add_idle(2);
    play(sched.size(), "sparse");
    check_prof("sparse");
  endtask

  task automatic test_zero_mask();
    sched.delete();
    add_run(4'b0000, 1'b0);
    add_idle(2);
    play(sched.size(), "zero_mask");
    check_prof("zero_mask");
  endtask

  task automatic test_ready_delay();
    sched.delete();
    rd_cfg[0] = 3; dd_cfg[0] = 0;
    rd_cfg[1] = 0; dd_cfg[1] = 2;
    add_run(4'b0011, 1'b0);
    add_idle(2);
    play(sched.size(), "ready_delay");
    check_prof("ready_delay");
  endtask

  task automatic test_spurious();
    sched.delete();
    for (int k = 0; k < NS; k++) begin rd_cfg[k] = 0; dd_cfg[k] = 3; end
    add_run(4'b0101, 1'b0);          // entries 0..9, stage 0 WAIT at 2..4
    sched[2].dn[2] = 1'b1; sched[2].spur = 1'b1;
    sched[9].dn[1] = 1'b1; sched[9].spur = 1'b1;
    add_idle(2);                     // entries 10, 11
    sched[10].dn[3] = 1'b1; sched[10].spur = 1'b1;
    add_run(4'b0001, 1'b0);
    add_idle(2);
    play(sched.size(), "spurious");
  endtask

  task automatic test_back_to_back();
    sched.delete();
    rand_cfg(2, 2);
    add_run(4'($urandom_range(15, 1)), 1'b1);
    rand_cfg(2, 2);
    add_run(4'b0000, 1'b1);
    rand_cfg(2, 2);
    add_run(4'($urandom_range(15, 1)), 1'b0);
    add_idle(2);
    play(sched.size(), "b2b");
    check_prof("b2b");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      sched.delete();
      rand_cfg(3, 4);
      add_run(4'($urandom), 1'b0);
      add_idle(1 + $urandom_range(2, 0));
      play(sched.size(), "random");
      check_prof("random");
    end
  endtask

  task automatic test_prof_clr_sat();
    sched.delete();
    rd_cfg[2] = 2; dd_cfg[2] = 20;
    add_run(4'b0100, 1'b0);
    add_idle(1);
    play(sched.size(), "prof_sat");
    check_prof("prof_sat");
    sched.delete();
    add_idle(2);
    sched[0].clr = 1'b1;
    for (int k = 0; k < NS; k++) exp_prof[k] = 0;
    play(sched.size(), "prof_clr");
    check_prof("prof_clr");
  endtask

  task automatic test_reset_mid();
    sched.delete();
    rd_cfg[0] = 0; dd_cfg[0] = 1;
    rd_cfg[1] = 0; dd_cfg[1] = 5;
    add_run(4'b0011, 1'b0);          // stage 1 WAIT from entry 4
    sched[2].dn[3] = 1'b1; sched[2].spur = 1'b1;
    play(6, "reset_mid");
    #2;
    ap_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ap_idle, ap_done, ap_ready, err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_mid.ctrl got=%b exp=1000", {ap_idle, ap_done, ap_ready, err});
    end
    n_cmp++;
    if ({stg_start, cur_stage} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_mid.stage got=%b exp=000000", {stg_start, cur_stage});
    end
    n_cmp++;
    if (prof_cycles !== '0) begin
      n_fail++;
      $display("FAIL reset_mid.prof got=%h exp=0", prof_cycles);
    end
    m_err = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    sched.delete();
    rd_cfg[0] = 1; dd_cfg[0] = 2;
    add_run(4'b0001, 1'b0);
    add_idle(2);
    play(sched.size(), "after_reset");
    check_prof("after_reset");
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_all_stages();
    test_sparse_mask();
    test_zero_mask();
    test_ready_delay();
    test_spurious();
    test_back_to_back();
    test_random();
    test_prof_clr_sat();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
